// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// trained by EX-stage resolutions, with registered mispredict flush/redirect and statistics.
module branch_predictor #(
    parameter int N     = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     if_pc,
    output logic             pred_taken,
    output logic [N-1:0]     pred_target,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic [N-1:0]     res_pc,
    input  logic             res_taken,
    input  logic [N-1:0]     res_target,
    input  logic             res_pred_taken,
    input  logic [N-1:0]     res_pred_target,
    output logic             flush,
    output logic [N-1:0]     redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int ENTRIES = 2 ** IDX_W;
    localparam int TAG_W   = N - IDX_W - 2;
    localparam logic [N-1:0] PC_STEP = N'(4);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [N-1:0]     target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] res_idx;
    logic [TAG_W-1:0] if_tag;
    logic [TAG_W-1:0] res_tag;
    logic             lookup_hit;
    logic             res_hit;
    logic             res_event;
    logic             mispredict;
    logic [1:0]       ctr_next;

    // Lookup reads only registered table state, so a write becomes visible after its edge.
    always_comb begin
        if_idx      = if_pc[IDX_W+1:2];
        if_tag      = if_pc[N-1:IDX_W+2];
        lookup_hit  = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = lookup_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_STEP;
    end

    always_comb begin
        res_idx    = res_pc[IDX_W+1:2];
        res_tag    = res_pc[N-1:IDX_W+2];
        res_hit    = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        res_event  = res_valid && res_is_branch;
        mispredict = res_event &&
                     ((res_taken != res_pred_taken) ||
                      (res_taken && (res_target != res_pred_target)));
        ctr_next   = ctr_q[res_idx];
        if (res_hit) begin
            if (res_taken && (ctr_q[res_idx] != 2'b11)) begin
                ctr_next = ctr_q[res_idx] + 2'b01;
            end else if (!res_taken && (ctr_q[res_idx] != 2'b00)) begin
                ctr_next = ctr_q[res_idx] - 2'b01;
            end
        end else begin
            ctr_next = res_taken ? 2'b10 : 2'b01;
        end
    end

    // A miss allocates over whatever lived at the index; a hit only refreshes the target when taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (res_event) begin
            valid_q[res_idx] <= 1'b1;
            tag_q[res_idx]   <= res_tag;
            ctr_q[res_idx]   <= ctr_next;
            if (!res_hit || res_taken) begin
                target_q[res_idx] <= res_target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
        end else begin
            flush <= mispredict;
            if (mispredict) begin
                redirect_pc <= res_taken ? res_target : res_pc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_count  <= '0;
            mispred_count <= '0;
        end else begin
            if (res_event && (branch_count != {CNT_W{1'b1}})) begin
                branch_count <= branch_count + 1'b1;
            end
            if (mispredict && (mispred_count != {CNT_W{1'b1}})) begin
                mispred_count <= mispred_count + 1'b1;
            end
        end
    end
endmodule
